dbg_clk_ctrl: RTL and testbench

//  Parametrised CPU run-control unit for the SOPC top: free-running clock-enable divider,
//  NUM_BP PC breakpoint comparators, debounced single-step key and a registered probe mux.

---
 rtl/dbg_clk_ctrl_pkg.sv | 14 +
 rtl/dbg_clk_ctrl_key_sync_debounce.sv | 44 ++++
 rtl/dbg_clk_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dbg_clk_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_clk_ctrl_pkg.sv
// Shared types and constants for the CPU run-control block.
// The state encoding matches the legacy DBG_HALT/DBG_RUN/DBG_STEP defines.
package dbg_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    DBG_HALT = 2'b00,
    DBG_RUN  = 2'b01,
    DBG_STEP = 2'b10
  } dbg_state_e;

  localparam int CE_CNT_W  = 32;
  localparam int DEB_CNT_W = 16;

endpackage

// File: rtl/dbg_clk_ctrl_key_sync_debounce.sv
// Step push-button front end: 2-FF synchroniser, stability debouncer and a
// rising-edge detector that emits a single-clock pulse per accepted press.
module key_sync_debounce
  import dbg_clk_ctrl_pkg::*;
#(
  parameter logic [DEB_CNT_W-1:0] DEB_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic pulse_o
);

  logic                 key_s1;
  logic                 key_s2;
  logic                 key_db;
  logic [DEB_CNT_W-1:0] deb_cnt;

  // The debounced level only follows the synchronised key after DEB_CYC
  // consecutive cycles of disagreement; any return to key_db restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1  <= 1'b0;
      key_s2  <= 1'b0;
      key_db  <= 1'b0;
      deb_cnt <= '0;
      pulse_o <= 1'b0;
    end else begin
      key_s1  <= key_i;
      key_s2  <= key_s1;
      pulse_o <= 1'b0;
      if (key_s2 == key_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt >= DEB_CYC - 16'd1) begin
        deb_cnt <= '0;
        key_db  <= key_s2;
        pulse_o <= key_s2;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/dbg_clk_ctrl.sv
// CPU run-control: clock-enable divider, PC breakpoints, run/halt/step FSM,
// CE pulse counter and a registered probe multiplexer.
module dbg_clk_ctrl
  import dbg_clk_ctrl_pkg::*;
#(
  parameter int                   DIV_W     = 4,
  parameter int                   ADDR_W    = 32,
  parameter int                   NUM_BP    = 4,
  parameter int                   PROBE_NUM = 16,
  parameter int                   PROBE_W   = 32,
  parameter int                   SEL_W     = 4,
  parameter logic [DEB_CNT_W-1:0] DEB_CYC   = 16'd50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIV_W-1:0]             div_i,
  input  logic                         run_i,
  input  logic                         step_key_i,
  input  logic [NUM_BP-1:0]            bp_en_i,
  input  logic [NUM_BP*ADDR_W-1:0]     bp_addr_i,
  input  logic [ADDR_W-1:0]            pc_i,
  input  logic [PROBE_NUM*PROBE_W-1:0] probe_i,
  input  logic [SEL_W-1:0]             probe_sel_i,
  output logic                         cpu_ce_o,
  output logic                         halted_o,
  output logic [NUM_BP-1:0]            bp_hit_o,
  output logic [PROBE_W-1:0]           probe_o,
  output logic [CE_CNT_W-1:0]          ce_cnt_o,
  output dbg_state_e                   dbg_state_o
);

  // Handshake note: this block has no valid/ready interfaces; cpu_ce_o is a
  // one-clock qualifier that downstream logic samples on the same clk edge.

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic                run_q;
  logic                run_rise;
  logic                step_pulse;
  logic [NUM_BP-1:0]   bp_match;
  dbg_state_e          state_q;
  dbg_state_e          state_d;
  logic                skip_q;
  logic                skip_d;
  logic                cpu_ce_q;
  logic                cpu_ce_d;
  logic [NUM_BP-1:0]   bp_hit_q;
  logic [NUM_BP-1:0]   bp_hit_d;
  logic [CE_CNT_W-1:0] ce_cnt_q;
  logic [PROBE_W-1:0]  probe_q;
  logic [PROBE_W-1:0]  probe_d;

  key_sync_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_key (
    .clk     (clk),
    .rst     (rst),
    .key_i   (step_key_i),
    .pulse_o (step_pulse)
  );

  // Comparing with >= lets a lowered div_i take effect on the very next cycle.
  assign tick = (div_cnt >= div_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // run_q resets high so a run_i already asserted at reset exit is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b1;
    end else begin
      run_q <= run_i;
    end
  end

  assign run_rise = run_i & ~run_q;

  always_comb begin
    bp_match = '0;
    for (int k = 0; k < NUM_BP; k++) begin
      bp_match[k] = bp_en_i[k] && (pc_i == bp_addr_i[k*ADDR_W +: ADDR_W]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DBG_HALT;
      skip_q   <= 1'b0;
      cpu_ce_q <= 1'b0;
      bp_hit_q <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      cpu_ce_q <= cpu_ce_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  // skip lets a resume from a breakpoint execute the instruction at that PC.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    cpu_ce_d = 1'b0;
    bp_hit_d = bp_hit_q;
    case (state_q)
      DBG_HALT: begin
        if (run_rise) begin
          state_d  = DBG_RUN;
          skip_d   = 1'b1;
          bp_hit_d = '0;
        end else if (step_pulse) begin
          state_d  = DBG_STEP;
          bp_hit_d = '0;
        end
      end
      DBG_RUN: begin
        if (tick) begin
          if (!run_i) begin
            state_d = DBG_HALT;
          end else if ((|bp_match) && !skip_q) begin
            state_d  = DBG_HALT;
            bp_hit_d = bp_match;
          end else begin
            cpu_ce_d = 1'b1;
            skip_d   = 1'b0;
          end
        end
      end
      DBG_STEP: begin
        if (tick) begin
          cpu_ce_d = 1'b1;
          state_d  = DBG_HALT;
        end
      end
      default: begin
        state_d = DBG_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_cnt_q <= '0;
    end else begin
      ce_cnt_q <= ce_cnt_q + {{(CE_CNT_W-1){1'b0}}, cpu_ce_q};
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    probe_d = '0;
    for (int k = 0; k < PROBE_NUM; k++) begin
      if (32'(probe_sel_i) == k) begin
        probe_d = probe_i[k*PROBE_W +: PROBE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      probe_q <= '0;
    end else begin
      probe_q <= probe_d;
    end
  end

  assign cpu_ce_o    = cpu_ce_q;
  assign halted_o    = (state_q == DBG_HALT);
  assign bp_hit_o    = bp_hit_q;
  assign probe_o     = probe_q;
  assign ce_cnt_o    = ce_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dbg_clk_ctrl.sv
// Bench for dbg_clk_ctrl: randomized run/breakpoint/step/probe scenarios checked
// against periodic-CE arithmetic, a pulse monitor and a probe expectation queue.
module tb_dbg_clk_ctrl;
  import dbg_clk_ctrl_pkg::*;

  localparam int DEB   = 20;
  localparam int NBP   = 4;
  localparam int PNUM  = 12;
  localparam int PW    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [3:0]          div_i = '0;
  logic                run_i = 1'b0;
  logic                step_key_i = 1'b0;
  logic [NBP-1:0]      bp_en_i = '0;
  logic [NBP*32-1:0]   bp_addr_i = '0;
  logic [31:0]         pc_i = '0;
  logic [PNUM*PW-1:0]  probe_i = '0;
  logic [3:0]          probe_sel_i = '0;
  logic                cpu_ce_o;
  logic                halted_o;
  logic [NBP-1:0]      bp_hit_o;
  logic [PW-1:0]       probe_o;
  logic [31:0]         ce_cnt_o;
  dbg_state_e          dbg_state_o;

  dbg_clk_ctrl #(
    .DIV_W     (4),
    .ADDR_W    (32),
    .NUM_BP    (NBP),
    .PROBE_NUM (PNUM),
    .PROBE_W   (PW),
    .SEL_W     (4),
    .DEB_CYC   (16'(DEB))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .div_i       (div_i),
    .run_i       (run_i),
    .step_key_i  (step_key_i),
    .bp_en_i     (bp_en_i),
    .bp_addr_i   (bp_addr_i),
    .pc_i        (pc_i),
    .probe_i     (probe_i),
    .probe_sel_i (probe_sel_i),
    .cpu_ce_o    (cpu_ce_o),
    .halted_o    (halted_o),
    .bp_hit_o    (bp_hit_o),
    .probe_o     (probe_o),
    .ce_cnt_o    (ce_cnt_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          pulse_t[$];
  logic [31:0] exp_q[$];
  logic [31:0] ch[PNUM];
  logic [31:0] bpa[NBP];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      pulse_cnt = 0;
    end else if (cpu_ce_o) begin
      pulse_cnt++;
      pulse_t.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run();
    run_i = 1'b0;
    cycles(2);
    run_i = 1'b1;
    cycles(1);
  endtask

  task automatic stop_run(input int d);
    run_i = 1'b0;
    cycles(d + 3);
  endtask

  task automatic press_step(input int hold);
    step_key_i = 1'b1;
    cycles(hold);
    step_key_i = 1'b0;
    cycles(DEB + 8);
  endtask

  task automatic pack_inputs();
    for (int k = 0; k < PNUM; k++) probe_i[k*PW +: PW] = ch[k];
    for (int k = 0; k < NBP; k++) bp_addr_i[k*32 +: 32] = bpa[k];
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ce"}, cpu_ce_o, 0);
    check_eq({tag, "_halted"}, halted_o, 1);
    check_eq({tag, "_bp_hit"}, bp_hit_o, 0);
    check_eq({tag, "_probe"}, probe_o, 0);
    check_eq({tag, "_ce_cnt"}, ce_cnt_o, 0);
  endtask

  // stimulus
  initial begin
    int d, k, w, base, ok, sel;
    int divs[4];
    logic [31:0] target, exp_p;
    logic [3:0]  en, mm, exp_bp;

    for (int i = 0; i < PNUM; i++) ch[i] = $urandom;
    for (int i = 0; i < NBP; i++) bpa[i] = $urandom;
    pack_inputs();

    // reset with run_i already high: no start without a fresh edge
    run_i = 1'b1;
    div_i = 4'd3;
    cycles(3);
    sync_neg();
    check_reset_values("reset");
    rst = 1'b1;
    cycles(20);
    sync_neg();
    check_eq("no_run_at_reset_exit_halted", halted_o, 1);
    check_eq("no_run_at_reset_exit_ce", pulse_cnt, 0);

    // free-running CE period = div+1
    divs[0] = 3; divs[1] = 0; divs[2] = 7; divs[3] = $urandom_range(1, 15);
    for (int t = 0; t < 4; t++) begin
      d = divs[t];
      k = (t == 0) ? 10 : $urandom_range(3, 8);
      w = k * (d + 1);
      div_i = 4'(d);
      start_run();
      cycles(3 * (d + 1) + 4);
      sync_neg();
      base = pulse_cnt;
      pulse_t.delete();
      repeat (w) @(negedge clk);
      #1;
      check_eq("run_ce_window", pulse_cnt - base, k);
      ok = 1;
      for (int i = 1; i < pulse_t.size(); i++)
        if (pulse_t[i] - pulse_t[i-1] != d + 1) ok = 0;
      check_eq("run_ce_spacing", ok, 1);
      check_eq("run_not_halted", halted_o, 0);
      check_eq("ce_cnt_track", ce_cnt_o, pulse_cnt - int'(cpu_ce_o));
      @(posedge clk); #1;
      run_i = 1'b0;
      sync_neg();
      base = pulse_cnt;
      cycles(2 * (d + 1) + 2);
      sync_neg();
      check_eq("stop_no_ce", pulse_cnt - base, 0);
      check_eq("stop_halted", halted_o, 1);
    end

    // breakpoints, followed by a single step off the breakpoint
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 5);
      div_i = 4'(d);
      if (it == 0) begin
        target = 32'h8000_0010; en = 4'b0001; mm = 4'b0001;
      end else if (it == 1) begin
        target = 32'h8000_0010; en = 4'b1111; mm = 4'b0101;
      end else begin
        target = $urandom & 32'hFFFF_FFFC;
        mm = 4'($urandom_range(1, 15));
        en = 4'($urandom_range(0, 15));
      end
      for (int i = 0; i < NBP; i++)
        bpa[i] = mm[i] ? target : (target ^ ($urandom | 32'h100));
      exp_bp = en & mm;
      bp_en_i = en;
      pack_inputs();
      pc_i = target ^ 32'h1;
      start_run();
      cycles(3 * (d + 1) + 4);
      @(posedge clk); #1;
      pc_i = target;
      sync_neg();
      base = pulse_cnt;
      cycles(2 * (d + 1) + 3);
      sync_neg();
      if (exp_bp != 0) begin
        check_eq("bp_halted", halted_o, 1);
        check_eq("bp_hit", bp_hit_o, exp_bp);
        check_eq("bp_no_ce", pulse_cnt - base, 0);
        base = pulse_cnt;
        press_step(DEB + 8);
        sync_neg();
        check_eq("step_one_ce", pulse_cnt - base, 1);
        check_eq("step_halted", halted_o, 1);
        check_eq("step_bp_hit_clear", bp_hit_o, 0);
        run_i = 1'b0;
      end else begin
        check_eq("bp_disabled_running", halted_o, 0);
        check_eq("bp_disabled_ce", (pulse_cnt - base) > 0, 1);
        check_eq("bp_disabled_hit", bp_hit_o, 0);
        stop_run(d);
      end
    end
    bp_en_i = '0;

    // short bounces never produce a step
    div_i = 4'd2;
    cycles(4);
    sync_neg();
    base = pulse_cnt;
    for (int b = 0; b < 10; b++) begin
      step_key_i = 1'b1;
      cycles($urandom_range(1, DEB - 3));
      step_key_i = 1'b0;
      cycles($urandom_range(1, DEB - 3));
    end
    cycles(DEB + 8);
    sync_neg();
    check_eq("bounce_no_step", pulse_cnt - base, 0);
    check_eq("bounce_halted", halted_o, 1);

    // a step press during RUN adds no CE and is not queued
    d = $urandom_range(0, 4);
    div_i = 4'(d);
    k = 90 / (d + 1) + 1;
    w = k * (d + 1);
    start_run();
    cycles(3 * (d + 1) + 4);
    sync_neg();
    base = pulse_cnt;
    for (int i = 0; i < w; i++) begin
      step_key_i = (i >= 2) && (i < 2 + DEB + 8);
      @(negedge clk);
      #1;
    end
    check_eq("step_in_run_window", pulse_cnt - base, k);
    run_i = 1'b0;
    cycles(d + 3);
    sync_neg();
    base = pulse_cnt;
    cycles(DEB + 10);
    sync_neg();
    check_eq("step_not_queued", pulse_cnt - base, 0);

    // probe mux: expectation queue, one-cycle latency
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_p = exp_q.pop_front();
        check_eq("probe", probe_o, exp_p);
      end
      if (i == 0) sel = 5;
      else if (i == 1) sel = 15;
      else sel = $urandom_range(0, 15);
      if (i < 21) begin
        if ($urandom_range(0, 1) == 1) begin
          ch[$urandom_range(0, PNUM - 1)] = $urandom;
          pack_inputs();
        end
        probe_sel_i = 4'(sel);
        exp_q.push_back((sel < PNUM) ? ch[sel] : 32'h0);
      end
    end

    // CE counter wrap
    force dut.ce_cnt_q = 32'hFFFF_FFFF;
    cycles(2);
    release dut.ce_cnt_q;
    cycles(1);
    sync_neg();
    check_eq("ce_cnt_forced", ce_cnt_o, 32'hFFFF_FFFF);
    press_step(DEB + 8);
    sync_neg();
    check_eq("ce_cnt_wrap", ce_cnt_o, 0);

    // asynchronous reset mid-RUN
    ch[5] = $urandom | 32'h1;
    pack_inputs();
    probe_sel_i = 4'd5;
    div_i = 4'd1;
    start_run();
    cycles(20);
    sync_neg();
    check_eq("pre_reset_running", halted_o, 0);
    check_eq("pre_reset_probe", probe_o, ch[5]);
    rst = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    #2;
    rst = 1'b1;
    cycles(20);
    sync_neg();
    check_eq("post_reset_halted", halted_o, 1);
    check_eq("post_reset_no_ce", pulse_cnt, 0);
    check_eq("post_reset_ce_cnt", ce_cnt_o, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
